// File: rtl/dtmf_peak_detector.sv
// Streaming DTMF peak detector: per-bin squared magnitude, low/high band peak search, valid/ready result.
// Optional macro TWIST_CHECK_EN adds a +/-8x band-power twist test to tone_present.
module dtmf_peak_detector #(
  parameter int unsigned DW      = 8,
  parameter int unsigned NBINS   = 64,
  parameter int unsigned BIN_W   = 6,
  parameter int unsigned LOW_LO  = 19,
  parameter int unsigned LOW_HI  = 25,
  parameter int unsigned HIGH_LO = 32,
  parameter int unsigned HIGH_HI = 43,
  parameter int unsigned MIN_MAG = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIN_W-1:0]     low_bin,
  output logic [BIN_W-1:0]     high_bin,
  output logic [2*DW:0]        low_mag,
  output logic [2*DW:0]        high_mag,
  output logic                 tone_present,
  output logic                 frame_err
);

  localparam int unsigned MW = 2 * DW + 1;
  localparam int unsigned TW = 2 * DW + 4;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic [MW-1:0]    mag;
  } peak_t;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_HOLD} state_e;

  state_e           state_q, state_d;
  logic [BIN_W-1:0] cnt_q, cnt_d;
  logic             pipe_vld_q, pipe_vld_d;
  logic [MW-1:0]    pipe_mag_q, pipe_mag_d;
  logic [BIN_W-1:0] pipe_idx_q, pipe_idx_d;
  logic             pipe_low_q, pipe_low_d;
  logic             pipe_high_q, pipe_high_d;
  peak_t            low_max_q, low_max_d;
  peak_t            high_max_q, high_max_d;
  peak_t            low_out_q, low_out_d;
  peak_t            high_out_q, high_out_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             tone_q, tone_d;
  logic             ferr_q, ferr_d;

  logic              accept_c, take_c, clr_c, last_c, tone_c, twist_ok_c;
  logic [BIN_W-1:0]  idx_c;
  logic signed [MW-1:0] re_x_c, im_x_c;
  logic [MW-1:0]     mag_c;

  assign accept_c = in_valid && in_ready_q;
  assign idx_c    = in_first ? '0 : cnt_q + BIN_W'(1);
  assign last_c   = (idx_c == BIN_W'(NBINS - 1));
  assign take_c   = accept_c && ((state_q == S_SCAN) || ((state_q == S_IDLE) && in_first));
  assign clr_c    = take_c && in_first;

  // Exact magnitude: sign-extend first so the squares cannot overflow.
  assign re_x_c = MW'(in_re);
  assign im_x_c = MW'(in_im);
  assign mag_c  = $unsigned(re_x_c * re_x_c) + $unsigned(im_x_c * im_x_c);

`ifdef TWIST_CHECK_EN
  logic [TW-1:0] low_w_c, high_w_c;
  assign low_w_c    = TW'(low_max_q.mag);
  assign high_w_c   = TW'(high_max_q.mag);
  assign twist_ok_c = (low_w_c <= (high_w_c << 3)) && (high_w_c <= (low_w_c << 3));
`else
  assign twist_ok_c = 1'b1;
`endif

  assign tone_c = (low_max_q.mag >= MW'(MIN_MAG)) && (high_max_q.mag >= MW'(MIN_MAG)) && twist_ok_c;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c && in_first) state_d = S_SCAN;
      S_SCAN:  if (accept_c && last_c) state_d = S_DRAIN;
      // Stay until the last registered magnitude has been folded into the maxima.
      S_DRAIN: if (!pipe_vld_q) state_d = S_HOLD;
      S_HOLD:  if (out_valid_q && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    pipe_vld_d  = take_c;
    pipe_mag_d  = pipe_mag_q;
    pipe_idx_d  = pipe_idx_q;
    pipe_low_d  = pipe_low_q;
    pipe_high_d = pipe_high_q;
    low_max_d   = low_max_q;
    high_max_d  = high_max_q;
    low_out_d   = low_out_q;
    high_out_d  = high_out_q;
    out_valid_d = out_valid_q;
    tone_d      = tone_q;
    ferr_d      = accept_c && in_first && (state_q == S_SCAN);
    in_ready_d  = (state_d != S_HOLD);

    if (take_c) begin
      cnt_d       = idx_c;
      pipe_mag_d  = mag_c;
      pipe_idx_d  = idx_c;
      pipe_low_d  = (idx_c >= BIN_W'(LOW_LO)) && (idx_c <= BIN_W'(LOW_HI));
      pipe_high_d = (idx_c >= BIN_W'(HIGH_LO)) && (idx_c <= BIN_W'(HIGH_HI));
    end

    // A new frame start discards whatever the pipeline still holds from the old one.
    if (clr_c) begin
      low_max_d  = '{bin: BIN_W'(LOW_LO), mag: '0};
      high_max_d = '{bin: BIN_W'(HIGH_LO), mag: '0};
    end else if (pipe_vld_q) begin
      if (pipe_low_q && (pipe_mag_q > low_max_q.mag))
        low_max_d = '{bin: pipe_idx_q, mag: pipe_mag_q};
      if (pipe_high_q && (pipe_mag_q > high_max_q.mag))
        high_max_d = '{bin: pipe_idx_q, mag: pipe_mag_q};
    end

    if ((state_q == S_DRAIN) && !pipe_vld_q) begin
      low_out_d   = low_max_q;
      high_out_d  = high_max_q;
      tone_d      = tone_c;
      out_valid_d = 1'b1;
    end else if ((state_q == S_HOLD) && out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      pipe_vld_q  <= 1'b0;
      pipe_mag_q  <= '0;
      pipe_idx_q  <= '0;
      pipe_low_q  <= 1'b0;
      pipe_high_q <= 1'b0;
      low_max_q   <= '0;
      high_max_q  <= '0;
      low_out_q   <= '0;
      high_out_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      tone_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_mag_q  <= pipe_mag_d;
      pipe_idx_q  <= pipe_idx_d;
      pipe_low_q  <= pipe_low_d;
      pipe_high_q <= pipe_high_d;
      low_max_q   <= low_max_d;
      high_max_q  <= high_max_d;
      low_out_q   <= low_out_d;
      high_out_q  <= high_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      tone_q      <= tone_d;
      ferr_q      <= ferr_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign low_bin      = low_out_q.bin;
  assign low_mag      = low_out_q.mag;
  assign high_bin     = high_out_q.bin;
  assign high_mag     = high_out_q.mag;
  assign tone_present = tone_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_dtmf_peak_detector.sv
// Directed self-checking bench for dtmf_peak_detector with a frame-level reference model.
module tb_dtmf_peak_detector;

  localparam int DW = 8;
  localparam int NB = 64;
  localparam int BW = 6;
  localparam int LLO = 19, LHI = 25, HLO = 32, HHI = 43, MINM = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n, in_valid, in_ready, in_first, out_valid, out_ready;
  logic signed [DW-1:0] in_re, in_im;
  logic [BW-1:0]        low_bin, high_bin;
  logic [2*DW:0]        low_mag, high_mag;
  logic                 tone_present, frame_err;

  dtmf_peak_detector dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_re(in_re), .in_im(in_im), .out_valid(out_valid),
    .out_ready(out_ready), .low_bin(low_bin), .high_bin(high_bin),
    .low_mag(low_mag), .high_mag(high_mag), .tone_present(tone_present),
    .frame_err(frame_err)
  );

  int checks = 0, errors = 0, ferr_cnt = 0;
  logic signed [DW-1:0] fre[NB], fim[NB];
  int exp_lb, exp_hb, exp_lm, exp_hm, exp_tone;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int magf(input int b);
    return int'(fre[b]) * int'(fre[b]) + int'(fim[b]) * int'(fim[b]);
  endfunction

  // Reference: strongest bin per band, first occurrence wins, then threshold and twist.
  task automatic model_expect();
    exp_lm = 0; exp_lb = LLO; exp_hm = 0; exp_hb = HLO;
    for (int b = LLO; b <= LHI; b++) if (magf(b) > exp_lm) begin exp_lm = magf(b); exp_lb = b; end
    for (int b = HLO; b <= HHI; b++) if (magf(b) > exp_hm) begin exp_hm = magf(b); exp_hb = b; end
    exp_tone = (exp_lm >= MINM && exp_hm >= MINM) ? 1 : 0;
`ifdef TWIST_CHECK_EN
    if (exp_lm > 8 * exp_hm || exp_hm > 8 * exp_lm) exp_tone = 0;
`endif
  endtask

  task automatic clear_frame();
    for (int i = 0; i < NB; i++) begin fre[i] = '0; fim[i] = '0; end
  endtask

  task automatic set_bin(input int b, input int re, input int im);
    fre[b] = DW'(re); fim[b] = DW'(im);
  endtask

  task automatic drive_beats(input int from, input int to, input bit first);
    for (int b = from; b <= to; b++) begin
      in_valid = 1'b1;
      in_first = first && (b == from);
      in_re    = fre[b];
      in_im    = fim[b];
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_first = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    chk({tag, "_ov_e0"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_ov_e1"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_ov_e2"}, out_valid, 1);
  endtask

  task automatic lit(input string tag, input int lb, input int lm, input int hb, input int hm, input int tn);
    chk({tag, "_low_bin"}, int'(low_bin), lb);
    chk({tag, "_low_mag"}, int'(low_mag), lm);
    chk({tag, "_high_bin"}, int'(high_bin), hb);
    chk({tag, "_high_mag"}, int'(high_mag), hm);
    chk({tag, "_tone"}, int'(tone_present), tn);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  // Continuous compare against the model whenever a result is presented.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("in_ready_vs_hold", in_ready, out_valid ? 0 : 1);
      if (frame_err) ferr_cnt++;
      if (out_valid) begin
        chk("mdl_low_bin", int'(low_bin), exp_lb);
        chk("mdl_low_mag", int'(low_mag), exp_lm);
        chk("mdl_high_bin", int'(high_bin), exp_hb);
        chk("mdl_high_mag", int'(high_mag), exp_hm);
        chk("mdl_tone", int'(tone_present), exp_tone);
      end
    end
  end

  task automatic run_frame(input string tag, input int lb, input int lm, input int hb, input int hm, input int tn);
    model_expect();
    drive_beats(0, NB - 1, 1'b1);
    finish_frame(tag);
    lit(tag, lb, lm, hb, hm, tn);
    consume(tag);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
    clear_frame(); model_expect();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    lit("rst", 0, 0, 0, 0, 0);
    chk("rst_frame_err", frame_err, 0);
    reset_n = 1'b1;

    // Two clean tones, then a 10-cycle stall on the result port.
    clear_frame(); set_bin(21, 10, 0); set_bin(37, 0, -12);
    model_expect();
    drive_beats(0, NB - 1, 1'b1);
    finish_frame("A");
    lit("A", 21, 100, 37, 144, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_high_mag", int'(high_mag), 144);
    end
    consume("A");

    clear_frame(); set_bin(20, 5, 5); set_bin(23, 5, 5); set_bin(40, 6, 0);
    run_frame("B", 20, 50, 40, 36, 1);

    clear_frame(); set_bin(22, 3, 0); set_bin(35, 20, 0);
    run_frame("C", 22, 9, 35, 400, 0);

    // Band edges, out-of-band energy and the threshold equality.
    clear_frame();
    set_bin(18, 50, 0); set_bin(26, 50, 0); set_bin(44, 60, 0); set_bin(63, -128, -128);
    set_bin(19, 3, 1); set_bin(25, 4, 0); set_bin(32, 2, 2); set_bin(43, -4, 0);
    run_frame("D", 25, 16, 43, 16, 1);

    clear_frame(); set_bin(20, -128, -128); set_bin(33, -128, 0);
    run_frame("E", 20, 32768, 33, 16384, 1);

    clear_frame(); set_bin(21, 40, 0); set_bin(37, 10, 0);
`ifdef TWIST_CHECK_EN
    run_frame("TW", 21, 1600, 37, 100, 0);
`else
    run_frame("TW", 21, 1600, 37, 100, 1);
`endif

    clear_frame();
    run_frame("Z", LLO, 0, HLO, 0, 0);

    // Restart mid-frame: only the second frame may contribute.
    clear_frame(); set_bin(21, 100, 0); set_bin(35, 0, 90);
    drive_beats(0, 29, 1'b1);
    clear_frame(); set_bin(24, 7, 7); set_bin(43, -9, 4);
    model_expect();
    in_valid = 1'b1; in_first = 1'b1; in_re = fre[0]; in_im = fim[0];
    @(posedge clk); #1;
    chk("ferr_pulse", frame_err, 1);
    chk("ferr_no_ov", out_valid, 0);
    in_first = 1'b0; in_re = fre[1]; in_im = fim[1];
    @(posedge clk); #1;
    chk("ferr_one_cycle", frame_err, 0);
    drive_beats(2, NB - 1, 1'b0);
    finish_frame("F");
    lit("F", 24, 98, 43, 97, 1);
    consume("F");

    // Reset mid-frame clears everything; stray beats afterwards are ignored.
    clear_frame(); set_bin(21, 10, 0); set_bin(37, 0, -12);
    drive_beats(0, 39, 1'b1);
    in_valid = 1'b1; in_re = 8'sd50; in_im = 8'sd0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_frame_err", frame_err, 0);
    lit("mrst", 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    repeat (70) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("stray_no_ov", out_valid, 0);
    chk("stray_low_mag", int'(low_mag), 0);

    run_frame("A2", 21, 100, 37, 144, 1);

    chk("frame_err_total", ferr_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
